// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared types and helpers for the Wishbone round-robin arbiter and any
//   later arbiters that reuse rr_pick.
//   - arb_state_t   : arbiter FSM encoding (IDLE / OWNED / ABORT)
//   - MAX_REQ       : largest supported requester count
//   - owner_w()     : width of an owner index for n requesters
//   - onehot_to_idx : one-hot grant vector -> binary index
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 8;

  // Owner index width; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // OR-reduction of set bit positions; exact when the input is one-hot,
  // and 0 for an all-zero vector.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches req starting at last+1,
//   wrapping modulo N, and returns the first asserted index.
//   Ports:
//     req  in  N   request vector
//     last in  OW  index of the most recent owner
//     vld  out 1   at least one request is set
//     idx  out OW  selected index (0 when vld=0)
module rr_pick #(
  parameter int N  = 3,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] last,
  output logic          vld,
  output logic [OW-1:0] idx
);

  logic [OW-1:0] j;

  // Walk the ring from furthest to nearest so the nearest hit after
  // 'last' is the one that sticks.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j   = '0;
    for (int i = N; i >= 1; i--) begin
      j = OW'((int'(last) + i) % N);
      if (req[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin Wishbone classic arbiter sharing one master port among
//   NUM_REQ requesters. Ownership is locked for as long as the owner holds
//   CYC; a watchdog aborts a strobe that waits TIMEOUT_CYC cycles for ack.
//   Ports:
//     clk, rstn            clock, async active-low reset
//     req_cyc/stb/we       per-requester controls       [NUM_REQ]
//     req_adr/dat/sel      packed per-requester fields  (req i at i*W +: W)
//     req_ack, req_err     ack / timeout error, owner only
//     req_dat_r            read data broadcast to all requesters
//     m_cyc/stb/we/adr/dat/sel  master side toward the slave
//     m_ack, m_dat_r       slave response
//     gnt                  registered one-hot owner
//     timeout_pulse        one-cycle pulse while aborting
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_cyc,
  input  logic [NUM_REQ-1:0]        req_stb,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adr,
  input  logic [NUM_REQ*DATA_W-1:0] req_dat,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         req_dat_r,
  output logic                      m_cyc,
  output logic                      m_stb,
  output logic                      m_we,
  output logic [ADDR_W-1:0]         m_adr,
  output logic [DATA_W-1:0]         m_dat,
  output logic [SEL_W-1:0]          m_sel,
  input  logic                      m_ack,
  input  logic [DATA_W-1:0]         m_dat_r,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      timeout_pulse
);

  localparam int OWNER_W = owner_w(NUM_REQ);
  localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]    WD_LIMIT  = WD_W'(TIMEOUT_CYC);
  localparam logic [OWNER_W-1:0] LAST_RST  = OWNER_W'(NUM_REQ - 1);

  arb_state_t          state, state_nxt;
  logic [OWNER_W-1:0]  last_owner, owner, pick_idx;
  logic                pick_vld;
  logic [WD_W-1:0]     wd;
  logic                own_cyc, own_stb, wd_hit;

  // Owner index is derived from the registered grant so the two can never
  // disagree.
  assign owner   = OWNER_W'(onehot_to_idx(MAX_REQ'(gnt)));
  assign own_cyc = req_cyc[owner];
  assign own_stb = req_stb[owner] & own_cyc;
  assign wd_hit  = (wd == WD_LIMIT);

  assign req_dat_r = m_dat_r;

  rr_pick #(
    .N  (NUM_REQ),
    .OW (OWNER_W)
  ) u_pick (
    .req  (req_cyc),
    .last (last_owner),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_vld) state_nxt = OWNED;
      OWNED: begin
        if (!own_cyc)                        state_nxt = IDLE;
        else if (own_stb && !m_ack && wd_hit) state_nxt = ABORT;
      end
      ABORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    m_cyc         = 1'b0;
    m_stb         = 1'b0;
    m_we          = 1'b0;
    m_adr         = '0;
    m_dat         = '0;
    m_sel         = '0;
    req_ack       = '0;
    req_err       = '0;
    timeout_pulse = 1'b0;
    case (state)
      OWNED: begin
        m_cyc          = own_cyc;
        m_stb          = own_stb;
        m_we           = req_we[owner];
        m_adr          = req_adr[owner*ADDR_W +: ADDR_W];
        m_dat          = req_dat[owner*DATA_W +: DATA_W];
        m_sel          = req_sel[owner*SEL_W +: SEL_W];
        // An ack with no strobe outstanding is dropped here.
        req_ack[owner] = m_ack & own_stb;
      end
      ABORT: begin
        req_err[owner] = 1'b1;
        timeout_pulse  = 1'b1;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------- grant bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt        <= '0;
      last_owner <= LAST_RST;
    end else begin
      case (state)
        IDLE:  if (pick_vld) gnt <= NUM_REQ'(1) << pick_idx;
        OWNED: if (!own_cyc) begin
          gnt        <= '0;
          last_owner <= owner;
        end
        ABORT: begin
          gnt        <= '0;
          last_owner <= owner;
        end
        default: gnt <= '0;
      endcase
    end
  end

  // -------------------------------------------------------------- watchdog
  // Counts cycles an owner strobe waits; any gap, ack or idle cycle clears
  // it. Holding at the limit keeps the counter from wrapping on the abort
  // cycle when TIMEOUT_CYC fills the counter width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      wd <= '0;
    else if (state != OWNED || !own_stb || m_ack)
      wd <= '0;
    else if (!wd_hit)
      wd <= wd + 1'b1;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone (classic, single-cycle strobes) arbiter that shares the single UART Wishbone master port between NUM_REQ internal requesters: uart config, handshake and xmodem engines.
- Replaces a fixed mux select with dynamic, transaction-locked ownership.
- Adds a bus-hang watchdog so a non-responding slave cannot deadlock the gateway.
- Sits inside the gateway, between the requester engines and the UART Wishbone slave.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 5, Wishbone address width (matches UART address width).
- DATA_W, 32, Wishbone data width.
- SEL_W, 4, byte-select width.
- TIMEOUT_CYC, 255, max cycles a strobe may wait for ack before abort (1..65535).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_cyc  in  NUM_REQ  per-requester CYC
- req_stb  in  NUM_REQ  per-requester STB
- req_we  in  NUM_REQ  per-requester WE
- req_adr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_dat  in  NUM_REQ*DATA_W  packed write data
- req_sel  in  NUM_REQ*SEL_W  packed byte selects
- req_ack  out  NUM_REQ  ack routed to owner only
- req_err  out  NUM_REQ  timeout error routed to owner only
- req_dat_r  out  DATA_W  read data, broadcast to all requesters
- m_cyc, m_stb, m_we  out  1  master-side controls
- m_adr  out  ADDR_W  master address
- m_dat  out  DATA_W  master write data
- m_sel  out  SEL_W  master byte select
- m_ack  in  1  slave ack
- m_dat_r  in  DATA_W  slave read data
- gnt  out  NUM_REQ  one-hot current owner (registered)
- timeout_pulse  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rstn.
- Reset values:
  - gnt=0, m_cyc=m_stb=m_we=0, m_adr/m_dat/m_sel=0.
  - req_ack=req_err=0, timeout_pulse=0.
  - state=IDLE, last_owner=NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE:
    - If any req_cyc is set, pick the first asserted index searching last_owner+1, +2, … modulo NUM_REQ.
    - Register gnt one-hot and owner; go to OWNED next cycle.
    - Latency from request to m_cyc is 1 clk.
  - OWNED:
    - m_* driven combinationally from the owner's req_* (m_cyc = req_cyc[owner], m_stb = req_stb[owner] & req_cyc[owner]).
    - req_ack[owner] = m_ack & m_stb; all other ack/err are 0.
    - Ownership is held while req_cyc[owner]=1, including across multiple strobes (locked transactions).
    - When req_cyc[owner] drops: last_owner ← owner, gnt ← 0, next state IDLE.
    - One dead cycle always separates consecutive owners.
  - ABORT (1 cycle):
    - m_cyc=m_stb=0, req_err[owner]=1, timeout_pulse=1.
    - last_owner ← owner, gnt ← 0, next state IDLE.
    - The aborted requester must drop cyc; if it keeps cyc asserted it competes normally in round robin.
- Watchdog:
  - wd counter (width clog2(TIMEOUT_CYC+1)) clears to 0 in IDLE, on m_ack, or when m_stb=0.
  - Increments while m_stb=1 and m_ack=0.
  - When wd==TIMEOUT_CYC and m_ack=0, go to ABORT.
  - An ack arriving in the same cycle as the limit wins: no abort.
- Non-owner strobes are ignored; they never produce ack or err.
- m_ack arriving while m_stb=0 is ignored: not routed, no error.
- All req_cyc dropped in IDLE: stay in IDLE with gnt=0.
- Single requester continuously re-requesting: regranted after the dead cycle (no starvation issue).
- Reset asserted mid-transaction: immediate return to reset values; slave side sees m_cyc fall asynchronously.
- Owner index of 0 with last_owner wrap: a search from NUM_REQ-1 wraps to 0.

Decomposition:
- Package wb_arb_pkg:
  - state enum arb_state_t {IDLE, OWNED, ABORT}.
  - function onehot_to_idx.
  - OWNER_W = clog2(NUM_REQ) derivation helper.
- Sub-module rr_pick (combinational):
  - Inputs: req vector, last_owner.
  - Outputs: valid, next owner index.
  - Reusable by future RC-side arbiters.

Test Plan:
1. Reset then req_cyc=3'b001 with a single write strobe, slave acks after 2 clks -> gnt=001 one clk after request, m_adr/m_dat equal requester 0's, req_ack[0]=1 for 1 clk, gnt=000 the clk after cyc drops.
2. req_cyc=3'b111 held, each requester runs one strobe then drops cyc -> grant order 0,1,2,0 with exactly one dead cycle between owners.
3. Requester 1 holds cyc over 3 back-to-back strobes while requester 2 requests -> no switch until requester 1 drops cyc; requester 2 then granted.
4. Slave never acks, TIMEOUT_CYC=4 -> ABORT after 4 waiting cycles: req_err[owner]=1 and timeout_pulse=1 for 1 clk, m_cyc=0, next requester granted afterwards. Variant with ack exactly at cycle 4 -> no abort.
5. rstn pulsed low while requester 2 owns with stb pending -> all outputs 0 immediately; after release, requester 0 is the first grant.
6. Spurious m_ack with m_stb=0, and non-owner stb asserted -> no req_ack or req_err on any requester.
